fb_swap_scheduler: RTL
======================

# fb_swap_scheduler

Sequences the ping-pong frame buffer between the graphics controller and the display scan-out. It owns the bank-select state and clears each new draw bank with an internal engine. It then grants the graphics controller exclusive write access to that bank and swaps the display and draw banks only at the start of vertical blanking. It sits between the graphics controller's write stream and the ping-pong memory's write port, and takes hc/vc from the VGA timing generator.

## Interface
- FB_PIXELS, 76800 — framebuffer size in pixels (320×240); valid addresses 0..FB_PIXELS-1
- ADDR_W, 20 — write address width
- V_SWAP_LINE, 480 — vc value at which a bank swap is evaluated
- CLEAR_COLOR, 8'h00 — RGB332 value written by the clear engine

- clk  in  1  pixel clock; hc advances once per clk
- rst  in  1  asynchronous, active-low reset
- hc  in  10  display horizontal counter
- vc  in  10  display vertical counter
- gfx_req  in  1  graphics write request
- gfx_addr  in  ADDR_W  graphics write address (y*320+x)
- gfx_data  in  8  graphics write data, RGB332
- gfx_frame_done  in  1  one-cycle pulse: graphics finished the current frame
- gfx_grant  out  1  combinational; request accepted this cycle
- frame_start  out  1  one-cycle pulse: draw bank cleared, graphics may begin
- wr_en  out  1  memory write enable (registered)
- wr_addr  out  ADDR_W  memory write address (registered)
- wr_data  out  8  memory write data (registered)
- wr_bank  out  1  bank being written; always ~disp_bank
- disp_bank  out  1  bank scanned out by the display
- clearing  out  1  high while state is CLEAR
- dropped_frames  out  8  saturating count of swap points with no finished frame

## Operation
- States: CLEAR, DRAW, WAIT_SWAP.
- swap_tick = (vc == V_SWAP_LINE && hc == 0). It asserts for exactly one cycle per frame.
- CLEAR:
  - Each cycle, issue wr_en=1, wr_addr=clr_cnt, wr_data=CLEAR_COLOR, then increment clr_cnt.
  - After the write at FB_PIXELS-1, clr_cnt returns to 0 and the next state is DRAW.
  - frame_start pulses in the first DRAW cycle.
  - gfx_grant=0 throughout.
- DRAW:
  - gfx_grant = gfx_req.
  - A granted write registers wr_en=1, wr_addr=gfx_addr, wr_data=gfx_data.
  - If gfx_addr ≥ FB_PIXELS, the request is still granted but wr_en=0 (write dropped).
  - gfx_frame_done moves the state to WAIT_SWAP. A write granted in the same cycle is still performed.
- WAIT_SWAP:
  - gfx_grant=0, wr_en=0.
  - On swap_tick: toggle disp_bank, reset clr_cnt to 0, go to CLEAR.
- Frame drop:
  - A swap_tick while in CLEAR or DRAW leaves the state and disp_bank unchanged; the current frame is re-displayed.
  - dropped_frames increments, saturating at 255.
- gfx_frame_done in CLEAR or WAIT_SWAP is ignored.
- gfx_frame_done and swap_tick in the same DRAW cycle: the frame counts as done. disp_bank toggles and the next state is CLEAR. dropped_frames is unchanged.
- wr_bank is derived from the registered disp_bank. A swap therefore takes effect on wr_bank in the same cycle as on disp_bank.

## Timing
- Reset values:
  - state=CLEAR, clr_cnt=0, disp_bank=0 (so wr_bank=1).
  - wr_en=0, wr_addr=0, wr_data=0, frame_start=0.
  - clearing=1, dropped_frames=0.
  - gfx_grant=0 while rst low.
- First CLEAR write (wr_en=1, wr_addr=0) appears one cycle after rst deasserts.
- A clear takes exactly FB_PIXELS cycles of wr_en=1, with consecutive addresses.
- Graphics write latency: request in cycle N is granted combinationally in N; wr_* valid in N+1; one write per cycle sustained.
- disp_bank toggles on the clk edge ending the swap_tick cycle. The first CLEAR write to the new draw bank follows one cycle later.
- rst asserted mid-clear or mid-draw aborts immediately to reset values. The clear restarts from address 0 with disp_bank=0.
- FB_PIXELS (76800) plus full-frame draw time must fit within one 800×525 frame (420000 clk) to avoid drops. This is not enforced by the block.

## Test plan
- Reset, release, no stimulus → wr_en=1 for exactly 76800 cycles, addresses 0..76799, data 8'h00, wr_bank=1; then frame_start pulses once and clearing=0.
- In DRAW, gfx_req=1, gfx_addr=1234, gfx_data=8'hE3 → gfx_grant=1 same cycle. Next cycle: wr_en=1, wr_addr=1234, wr_data=8'hE3. Repeat with gfx_addr=80000 → granted, wr_en=0.
- gfx_frame_done pulse, then drive vc=480, hc=0 → disp_bank 0→1 and wr_bank=0 at that edge. Next cycle, CLEAR write to address 0 begins.
- Withhold gfx_frame_done across three swap_ticks → dropped_frames=3, disp_bank unchanged, state remains DRAW. Force 300 drops → dropped_frames saturates at 255.
- gfx_frame_done, gfx_req and swap_tick in the same cycle → write performed, disp_bank toggles, CLEAR entered, dropped_frames unchanged.
- Assert rst at clear address 40000 → all outputs reach reset values asynchronously. After release, the clear restarts at address 0 with wr_bank=1.

Source files
------------

// File: rtl/fb_swap_scheduler.sv
// ============================================================================
// fb_swap_scheduler : ping-pong frame buffer sequencer (clear / draw / swap)
// Rev 1.0
// ============================================================================
`default_nettype none

module fb_swap_scheduler #(
  parameter int         FB_PIXELS   = 76800,
  parameter int         ADDR_W      = 20,
  parameter int         V_SWAP_LINE = 480,
  parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [9:0]        hc_i,
  input  logic [9:0]        vc_i,
  input  logic              gfx_req_i,
  input  logic [ADDR_W-1:0] gfx_addr_i,
  input  logic [7:0]        gfx_data_i,
  input  logic              gfx_frame_done_i,
  output logic              gfx_grant_o,
  output logic              frame_start_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              wr_bank_o,
  output logic              disp_bank_o,
  output logic              clearing_o,
  output logic [7:0]        dropped_frames_o
);

  typedef enum logic [1:0] {
    S_CLEAR     = 2'd0,
    S_DRAW      = 2'd1,
    S_WAIT_SWAP = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);
  localparam logic [ADDR_W-1:0] FB_LIMIT  = ADDR_W'(FB_PIXELS);
  localparam logic [9:0]        SWAP_LINE = 10'(V_SWAP_LINE);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              disp_bank_q, disp_bank_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              frame_start_q, frame_start_d;
  logic [7:0]        dropped_q, dropped_d;

  logic swap_tick;
  logic grant;
  logic [7:0] dropped_inc;

  assign swap_tick   = (vc_i == SWAP_LINE) && (hc_i == 10'd0);
  assign grant       = (state_q == S_DRAW) && gfx_req_i;
  assign dropped_inc = (dropped_q == 8'hFF) ? dropped_q : dropped_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    disp_bank_d   = disp_bank_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_start_d = 1'b0;
    dropped_d     = dropped_q;

    case (state_q)
      S_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_cnt_q;
        wr_data_d = CLEAR_COLOR;
        if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d     = '0;
          state_d       = S_DRAW;
          frame_start_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
        // Clear not finished by the swap point: old frame is shown again.
        if (swap_tick) dropped_d = dropped_inc;
      end

      S_DRAW: begin
        // Out-of-range addresses are accepted but never reach the memory.
        if (gfx_req_i && (gfx_addr_i < FB_LIMIT)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = gfx_addr_i;
          wr_data_d = gfx_data_i;
        end
        if (gfx_frame_done_i && swap_tick) begin
          disp_bank_d = ~disp_bank_q;
          clr_cnt_d   = '0;
          state_d     = S_CLEAR;
        end else if (gfx_frame_done_i) begin
          state_d = S_WAIT_SWAP;
        end else if (swap_tick) begin
          dropped_d = dropped_inc;
        end
      end

      S_WAIT_SWAP: begin
        if (swap_tick) begin
          disp_bank_d = ~disp_bank_q;
          clr_cnt_d   = '0;
          state_d     = S_CLEAR;
        end
      end

      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_CLEAR;
      clr_cnt_q     <= '0;
      disp_bank_q   <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 8'h00;
      frame_start_q <= 1'b0;
      dropped_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      disp_bank_q   <= disp_bank_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_start_q <= frame_start_d;
      dropped_q     <= dropped_d;
    end
  end

  assign gfx_grant_o      = grant;
  assign frame_start_o    = frame_start_q;
  assign wr_en_o          = wr_en_q;
  assign wr_addr_o        = wr_addr_q;
  assign wr_data_o        = wr_data_q;
  assign wr_bank_o        = ~disp_bank_q;
  assign disp_bank_o      = disp_bank_q;
  assign clearing_o       = (state_q == S_CLEAR);
  assign dropped_frames_o = dropped_q;

endmodule

`default_nettype wire
